// File: rtl/stack_machine.sv
`default_nettype none
// ============================================================================
//  Module   : stack_machine
//  Purpose  : Parametrised LIFO stack with in-place DUP/SWAP/OVER/ADD/SUB.
//             Optional macro STACK_SAT_ARITH_EN selects saturating ADD/SUB.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_machine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic             apply,
    output logic [WIDTH-1:0] tail,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             valid,
    output logic             err
);

    localparam int       c_AW       = $clog2(DEPTH);
    localparam logic [2:0] c_OP_POP   = 3'd0;
    localparam logic [2:0] c_OP_DUP   = 3'd1;
    localparam logic [2:0] c_OP_SWAP  = 3'd2;
    localparam logic [2:0] c_OP_OVER  = 3'd3;
    localparam logic [2:0] c_OP_CLEAR = 3'd4;
    localparam logic [2:0] c_OP_PUSH  = 3'd5;
    localparam logic [2:0] c_OP_ADD   = 3'd6;
    localparam logic [2:0] c_OP_SUB   = 3'd7;

    // r_tail always mirrors r_mem[count-1], so T is read from the register.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_tail;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_valid;
    logic             r_err;

    logic [c_AW-1:0]  w_idx_n;
    logic [c_AW-1:0]  w_idx_t;
    logic [c_AW-1:0]  w_idx_s;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge2;
    logic             w_legal;
    logic             w_do;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_tail_nxt;
    logic             w_we0;
    logic [c_AW-1:0]  w_wa0;
    logic [WIDTH-1:0] w_wd0;
    logic             w_we1;
    logic [c_AW-1:0]  w_wa1;
    logic [WIDTH-1:0] w_wd1;

    assign w_idx_n = r_count[c_AW-1:0];
    assign w_idx_t = w_idx_n - c_AW'(1);
    assign w_idx_s = w_idx_n - c_AW'(2);
    assign w_s     = r_mem[w_idx_s];
    assign w_ge2   = (r_count >= CW'(2));

`ifdef STACK_SAT_ARITH_EN
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    assign w_sum  = {1'b0, w_s} + {1'b0, r_tail};
    assign w_diff = {1'b0, w_s} - {1'b0, r_tail};
    assign w_add  = w_sum[WIDTH]  ? '1 : w_sum[WIDTH-1:0];
    assign w_sub  = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
    assign w_add  = w_s + r_tail;
    assign w_sub  = w_s - r_tail;
`endif

    always_comb begin
        w_legal    = 1'b0;
        w_cnt_nxt  = r_count;
        w_tail_nxt = r_tail;
        w_we0      = 1'b0;
        w_wa0      = w_idx_n;
        w_wd0      = r_tail;
        w_we1      = 1'b0;
        w_wa1      = w_idx_s;
        w_wd1      = r_tail;
        case (op)
            c_OP_POP: begin
                w_legal    = !r_empty;
                w_cnt_nxt  = r_count - CW'(1);
                w_tail_nxt = w_ge2 ? w_s : '0;
            end
            c_OP_DUP: begin
                w_legal    = !r_empty && !r_full;
                w_cnt_nxt  = r_count + CW'(1);
                w_we0      = 1'b1;
            end
            c_OP_SWAP: begin
                w_legal    = w_ge2;
                w_tail_nxt = w_s;
                w_we0      = 1'b1;
                w_wa0      = w_idx_t;
                w_wd0      = w_s;
                w_we1      = 1'b1;
            end
            c_OP_OVER: begin
                w_legal    = w_ge2 && !r_full;
                w_cnt_nxt  = r_count + CW'(1);
                w_tail_nxt = w_s;
                w_we0      = 1'b1;
                w_wd0      = w_s;
            end
            c_OP_CLEAR: begin
                w_legal    = 1'b1;
                w_cnt_nxt  = '0;
                w_tail_nxt = '0;
            end
            c_OP_PUSH: begin
                w_legal    = !r_full;
                w_cnt_nxt  = r_count + CW'(1);
                w_tail_nxt = in;
                w_we0      = 1'b1;
                w_wd0      = in;
            end
            c_OP_ADD, c_OP_SUB: begin
                w_legal    = w_ge2;
                w_cnt_nxt  = r_count - CW'(1);
                w_tail_nxt = (op == c_OP_ADD) ? w_add : w_sub;
                w_we0      = 1'b1;
                w_wa0      = w_idx_s;
                w_wd0      = w_tail_nxt;
            end
            default: ;
        endcase
        w_do = apply && w_legal;
        // Idle or rejected ops leave every piece of state untouched.
        if (!w_do) begin
            w_cnt_nxt  = r_count;
            w_tail_nxt = r_tail;
            w_we0      = 1'b0;
            w_we1      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tail  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_tail  <= w_tail_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_valid <= w_do;
            r_err   <= apply && !w_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_we0) r_mem[w_wa0] <= w_wd0;
            if (w_we1) r_mem[w_wa1] <= w_wd1;
        end
    end

    assign tail  = r_tail;
    assign count = r_count;
    assign empty = r_empty;
    assign full  = r_full;
    assign valid = r_valid;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stack_machine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_machine
//  Purpose  : Directed and random checks of stack_machine against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_machine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic [2:0]       op = '0;
    logic             apply = 1'b0;
    logic [WIDTH-1:0] tail;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             valid;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;
    int q[$];

    always #5 clk = ~clk;

    stack_machine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in(in), .op(op), .apply(apply),
        .tail(tail), .empty(empty), .full(full), .count(count),
        .valid(valid), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int arith(input bit is_sub, input int s, input int t);
`ifdef STACK_SAT_ARITH_EN
        if (is_sub) return (t > s) ? 0 : s - t;
        return (s + t > MAXV) ? MAXV : s + t;
`else
        if (is_sub) return (s - t) & MAXV;
        return (s + t) & MAXV;
`endif
    endfunction

    // Apply one cycle of stimulus, advance the model, compare every output.
    task automatic step(input bit a, input logic [2:0] o, input int d, input bit r);
        int  n;
        int  t;
        int  s;
        bit  ok;
        bit  e_v;
        bit  e_e;
        @(negedge clk);
        rst   = r;
        apply = a;
        op    = o;
        in    = WIDTH'(d);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n   = q.size();
        ok  = 1'b0;
        e_v = 1'b0;
        e_e = 1'b0;
        if (r) begin
            q.delete();
        end else if (a) begin
            case (o)
                3'd0: begin ok = (n >= 1); if (ok) void'(q.pop_back()); end
                3'd1: begin ok = (n >= 1 && n < DEPTH); if (ok) q.push_back(q[n-1]); end
                3'd2: begin
                    ok = (n >= 2);
                    if (ok) begin t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t; end
                end
                3'd3: begin ok = (n >= 2 && n < DEPTH); if (ok) q.push_back(q[n-2]); end
                3'd4: begin ok = 1'b1; q.delete(); end
                3'd5: begin ok = (n < DEPTH); if (ok) q.push_back(d & MAXV); end
                default: begin
                    ok = (n >= 2);
                    if (ok) begin
                        t = q.pop_back();
                        s = q.pop_back();
                        q.push_back(arith(o == 3'd7, s, t));
                    end
                end
            endcase
            e_v = ok;
            e_e = !ok;
        end
        chk("tail",  32'(tail),  (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full",  32'(full),  32'(q.size() == DEPTH));
        chk("valid", 32'(valid), 32'(e_v));
        chk("err",   32'(err),   32'(e_e));
    endtask

    initial begin
        // Reset state
        step(1'b0, 3'd0, 0, 1'b1);
        chk("reset_tail", 32'(tail), 32'd0);

        // PUSH 1,2,9 then POP
        step(1'b1, 3'd5, 1, 1'b0);
        step(1'b1, 3'd5, 2, 1'b0);
        step(1'b1, 3'd5, 9, 1'b0);
        step(1'b1, 3'd0, 0, 1'b0);
        chk("t1_tail", 32'(tail), 32'd2);
        chk("t1_count", 32'(count), 32'd2);

        // CLEAR, PUSH 4,6, ADD, then SWAP on a single entry
        step(1'b1, 3'd4, 0, 1'b0);
        step(1'b1, 3'd5, 4, 1'b0);
        step(1'b1, 3'd5, 6, 1'b0);
        step(1'b1, 3'd6, 0, 1'b0);
        chk("t2_add", 32'(tail), 32'd10);
        step(1'b1, 3'd2, 0, 1'b0);
        chk("t2_swap_err", 32'(err), 32'd1);
        chk("t2_swap_tail", 32'(tail), 32'd10);

        // Underflow from empty, then an idle cycle
        step(1'b1, 3'd4, 0, 1'b0);
        step(1'b1, 3'd0, 0, 1'b0);
        chk("t3_pop_err", 32'(err), 32'd1);
        step(1'b0, 3'd5, 77, 1'b0);

        // Fill to DEPTH and try every growing op
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd5, 20 + i, 1'b0);
        chk("t4_full", 32'(full), 32'd1);
        step(1'b1, 3'd5, 99, 1'b0);
        chk("t4_push_tail", 32'(tail), 32'(20 + DEPTH - 1));
        step(1'b1, 3'd1, 0, 1'b0);
        step(1'b1, 3'd3, 0, 1'b0);
        step(1'b1, 3'd2, 0, 1'b0);
        step(1'b1, 3'd7, 0, 1'b0);

        // Overflow / underflow arithmetic
        step(1'b1, 3'd4, 0, 1'b0);
        step(1'b1, 3'd5, 250, 1'b0);
        step(1'b1, 3'd5, 10, 1'b0);
        step(1'b1, 3'd6, 0, 1'b0);
`ifdef STACK_SAT_ARITH_EN
        chk("t5_add", 32'(tail), 32'd255);
`else
        chk("t5_add", 32'(tail), 32'd4);
`endif
        step(1'b1, 3'd5, 3, 1'b0);
        step(1'b1, 3'd5, 5, 1'b0);
        step(1'b1, 3'd7, 0, 1'b0);
`ifdef STACK_SAT_ARITH_EN
        chk("t5_sub", 32'(tail), 32'd0);
`else
        chk("t5_sub", 32'(tail), 32'd254);
`endif

        // Reset wins over a simultaneous PUSH
        step(1'b1, 3'd5, 42, 1'b1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(valid), 32'd0);

        // Random traffic, biased toward PUSH so the full boundary is reached
        for (int i = 0; i < 600; i++) begin
            logic [2:0] o;
            o = ($urandom_range(0, 9) < 3) ? 3'd5 : 3'($urandom_range(0, 7));
            if (o == 3'd4 && $urandom_range(0, 3) != 0) o = 3'd5;
            step($urandom_range(0, 9) != 0, o, int'($urandom_range(0, MAXV)),
                 $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
